// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay/sound timers driven by a 60 Hz prescaler built on an external
// countdown Timer, with CPU write access and a square-wave buzzer.
module chip8_timer_ctrl #(
    parameter logic [15:0] TICK_RELOAD = 16'd999,
    parameter logic [15:0] TONE_HALF   = 16'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tmr_is_zero,
    output logic        tmr_set,
    output logic [15:0] tmr_value,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [7:0]  wr_data,
    output logic [7:0]  dt_value,
    output logic        st_active,
    output logic        frame_tick,
    output logic        tone
);

    localparam int unsigned REG_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               tmr_set_q, tmr_set_d;
    logic               frame_tick_q, frame_tick_d;
    logic [REG_W-1:0]   dt_q, dt_d;
    logic [REG_W-1:0]   st_q, st_d;
    logic [CNT_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic               tone_q, tone_d;

    // Prescaler FSM, timer registers and tone generator next-state logic
    always_comb begin
        state_d      = state_q;
        tmr_set_d    = 1'b0;
        frame_tick_d = 1'b0;
        dt_d         = dt_q;
        st_d         = st_q;
        tone_cnt_d   = tone_cnt_q;
        tone_d       = tone_q;

        // isZero is ignored in ARM so a still-zero Timer cannot double-tick
        case (state_q)
            S_INIT: begin
                tmr_set_d = 1'b1;
                state_d   = S_ARM;
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (tmr_is_zero) begin
                    tmr_set_d    = 1'b1;
                    frame_tick_d = 1'b1;
                    state_d      = S_ARM;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // A write on a tick edge overrides the decrement of that register only
        if (wr_en && !wr_sel) begin
            dt_d = wr_data;
        end else if (frame_tick_d && (dt_q != '0)) begin
            dt_d = dt_q - REG_W'(1);
        end

        if (wr_en && wr_sel) begin
            st_d = wr_data;
        end else if (frame_tick_d && (st_q != '0)) begin
            st_d = st_q - REG_W'(1);
        end

        // Phase only advances while ST stays non-zero across the edge
        if (st_d == '0) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (st_q != '0) begin
            if (tone_cnt_q == (TONE_HALF - CNT_W'(1))) begin
                tone_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            tmr_set_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            dt_q         <= '0;
            st_q         <= '0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_set_q    <= tmr_set_d;
            frame_tick_q <= frame_tick_d;
            dt_q         <= dt_d;
            st_q         <= st_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
        end
    end

    assign tmr_set    = tmr_set_q;
    assign tmr_value  = TICK_RELOAD;
    assign dt_value   = dt_q;
    assign st_active  = (st_q != '0);
    assign frame_tick = frame_tick_q;
    assign tone       = tone_q;

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Randomized self-checking bench for chip8_timer_ctrl against a
// tick-schedule / phase-count reference model, with a countdown Timer stand-in.
module tb_chip8_timer_ctrl;

    localparam int R  = 3;
    localparam int TH = 2;

    logic        clk;
    logic        reset;
    logic        tmr_is_zero;
    logic        tmr_set;
    logic [15:0] tmr_value;
    logic        wr_en;
    logic        wr_sel;
    logic [7:0]  wr_data;
    logic [7:0]  dt_value;
    logic        st_active;
    logic        frame_tick;
    logic        tone;

    chip8_timer_ctrl #(
        .TICK_RELOAD(16'(R)),
        .TONE_HALF  (16'(TH))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tmr_is_zero(tmr_is_zero),
        .tmr_set    (tmr_set),
        .tmr_value  (tmr_value),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .dt_value   (dt_value),
        .st_active  (st_active),
        .frame_tick (frame_tick),
        .tone       (tone)
    );

    // Generic countdown Timer: load on set, count down to zero and stay there
    logic [15:0] tmr_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                tmr_cnt <= 16'd0;
        else if (tmr_set)          tmr_cnt <= tmr_value;
        else if (tmr_cnt != 16'd0) tmr_cnt <= tmr_cnt - 16'd1;
    end
    assign tmr_is_zero = (tmr_cnt == 16'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference state: edges since reset release, DT/ST values, tone phase count
    int n_edge;
    int m_dt;
    int m_st;
    int m_ph;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_tick(input int k);
        return (k >= R + 3) && (((k - R - 3) % (R + 2)) == 0);
    endfunction

    task automatic cycle(input logic we, input logic sel, input logic [7:0] d);
        int  k;
        bit  tk;
        int  dt_n;
        int  st_n;
        wr_en   = we;
        wr_sel  = sel;
        wr_data = d;
        k  = n_edge + 1;
        tk = is_tick(k);
        dt_n = (we && !sel) ? int'(d) : (tk ? ((m_dt > 0) ? m_dt - 1 : 0) : m_dt);
        st_n = (we &&  sel) ? int'(d) : (tk ? ((m_st > 0) ? m_st - 1 : 0) : m_st);
        if (st_n == 0)      m_ph = 0;
        else if (m_st != 0) m_ph = (m_ph + 1) % (2 * TH);
        @(posedge clk);
        #1;
        n_edge = k;
        m_dt   = dt_n;
        m_st   = st_n;
        wr_en  = 1'b0;
        check_eq("frame_tick", 16'(frame_tick), 16'(tk));
        check_eq("tmr_set",    16'(tmr_set),    16'((k == 1) || tk));
        check_eq("dt_value",   16'(dt_value),   16'(m_dt));
        check_eq("st_active",  16'(st_active),  16'(m_st != 0));
        check_eq("tone",       16'(tone),       16'(m_ph >= TH));
        check_eq("tmr_value",  tmr_value,       16'(R));
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_dt",    16'(dt_value),   16'd0);
        check_eq("rst_st",    16'(st_active),  16'd0);
        check_eq("rst_tick",  16'(frame_tick), 16'd0);
        check_eq("rst_set",   16'(tmr_set),    16'd0);
        check_eq("rst_tone",  16'(tone),       16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        n_edge = 0;
        m_dt   = 0;
        m_st   = 0;
        m_ph   = 0;
    endtask

    task automatic run_to_tick_edge();
        for (int i = 0; i < 2 * (R + 3); i++) begin
            if (is_tick(n_edge + 1)) break;
            cycle(1'b0, 1'b0, 8'd0);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        n_edge = 0; m_dt = 0; m_st = 0; m_ph = 0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_eq("init_dt",   16'(dt_value),   16'd0);
        check_eq("init_tick", 16'(frame_tick), 16'd0);
        check_eq("init_tone", 16'(tone),       16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Free-running prescaler, no writes
        repeat (20) cycle(1'b0, 1'b0, 8'd0);

        // DT counts down to 0 and saturates
        cycle(1'b1, 1'b0, 8'd3);
        check_eq("dt_load3", 16'(dt_value), 16'd3);
        repeat (25) cycle(1'b0, 1'b0, 8'd0);
        check_eq("dt_sat0", 16'(dt_value), 16'd0);

        // Write wins over decrement on the tick edge; ST still decrements
        do_reset();
        cycle(1'b1, 1'b1, 8'd5);
        run_to_tick_edge();
        cycle(1'b1, 1'b0, 8'd9);
        check_eq("wr_vs_tick_dt", 16'(dt_value), 16'd9);
        check_eq("wr_vs_tick_st", 16'(m_st), 16'd4);
        repeat (25) cycle(1'b0, 1'b0, 8'd0);

        // ST = 2: tone runs for two ticks then stops
        cycle(1'b1, 1'b1, 8'd2);
        repeat (14) cycle(1'b0, 1'b0, 8'd0);

        // ST = 4 then cleared by write of 0 mid-tone, then restarted
        cycle(1'b1, 1'b1, 8'd4);
        repeat (3) cycle(1'b0, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 8'd0);
        check_eq("st_clr_active", 16'(st_active), 16'd0);
        check_eq("st_clr_tone",   16'(tone),       16'd0);
        cycle(1'b1, 1'b1, 8'd4);
        repeat (6) cycle(1'b0, 1'b0, 8'd0);

        // Async reset mid-period with both timers loaded
        cycle(1'b1, 1'b0, 8'd7);
        cycle(1'b1, 1'b1, 8'd7);
        cycle(1'b0, 1'b0, 8'd0);
        do_reset();
        repeat (12) cycle(1'b0, 1'b0, 8'd0);

        // Randomized writes with occasional async resets
        for (int i = 0; i < 3000; i++) begin
            logic       we;
            logic       sel;
            logic [7:0] d;
            we  = ($urandom % 4) == 0;
            sel = 1'($urandom % 2);
            d   = (($urandom % 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            if (($urandom % 400) == 0) do_reset();
            cycle(we, sel, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
